avg_fetch: RTL

//  Instruction fetch and sequencing stage of the AVG, directly upstream of avg_decode.

---
 rtl/avg_pkg.sv | 13 +
 rtl/avg_ret_stack.sv | 49 ++++
 rtl/avg_fetch.sv | 81 ++++++++
 3 files changed

// File: rtl/avg_pkg.sv
// avg_pkg: shared fetch-state encoding, instruction geometry and byte-lane map for the AVG fetch path
package avg_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} fetch_state_t;
  localparam int INST_BYTES = 4;
  localparam int AVG_RTS_W = 16;
  localparam logic [1:0] LANE_B0 = 2'd2;
  localparam logic [1:0] LANE_B1 = 2'd3;
  localparam logic [1:0] LANE_B2 = 2'd0;
  localparam logic [1:0] LANE_B3 = 2'd1;
  function automatic logic [1:0] byte_lane(input logic [1:0] k);
    return k == 2'd0 ? LANE_B0 : k == 2'd1 ? LANE_B1 : k == 2'd2 ? LANE_B2 : LANE_B3;
  endfunction
endpackage

// File: rtl/avg_ret_stack.sv
// avg_ret_stack: JSR/RTS return-address stack; AVG_STACK_ERR_EN selects saturate-with-fault, otherwise circular wrap
module avg_ret_stack import avg_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AVG_RTS_W-1:0] push_data,
  output logic [AVG_RTS_W-1:0] data,
  output logic                 full,
  output logic                 empty
);
  localparam int SP_W = $clog2(DEPTH);
  logic [AVG_RTS_W-1:0] mem [DEPTH];
  logic [SP_W-1:0] wr_idx;
  logic            do_push;
`ifdef AVG_STACK_ERR_EN
  logic [SP_W:0] cnt;
  assign full = cnt[SP_W];
  assign empty = ~|cnt;
  assign wr_idx = cnt[SP_W-1:0];
  assign do_push = push & ~full;
  assign data = mem[cnt[SP_W-1:0] - 1'b1];
  // occupancy count; pushes when full and pops when empty are refused
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (do_push) cnt <= cnt + 1'b1;
    else if (pop & ~empty) cnt <= cnt - 1'b1;
  end
`else
  logic [SP_W-1:0] sp;
  assign full = 1'b0;
  assign empty = 1'b0;
  assign wr_idx = sp;
  assign do_push = push;
  assign data = mem[sp - 1'b1];
  // circular pointer; overflow overwrites the oldest entry, underflow reads the wrapped one
  always_ff @(posedge clk) begin
    if (rst) sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop) sp <= sp - 1'b1;
  end
`endif
  // entry storage, written at the current top on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end
endmodule

// File: rtl/avg_fetch.sv
// avg_fetch: AVG instruction fetch/sequencing (byte fetch, word assembly, PC/JMP/JSR/RTS/HALT); AVG_STACK_ERR_EN enables stack fault detection
module avg_fetch import avg_pkg::*; #(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              jmp,
  input  logic              jsr,
  input  logic              ret,
  input  logic              halt,
  input  logic [15:0]       jump_addr,
  input  logic [2:0]        pc_offset,
  output logic              halted,
  output logic              stack_err
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_seq;
  logic [1:0] cnt;
  logic [31:0] inst_q;
  logic hs, do_push, do_pop, full, empty, err_q, capture;
  logic [AVG_RTS_W-1:0] rts_top;
  assign hs = state == VALID && inst_ready;
  assign pc_seq = pc + ADDR_W'(pc_offset);
  assign do_pop = hs & ~halt & ret;
  assign do_push = hs & ~halt & ~ret & jmp & jsr;
  assign mem_rd = state == FETCH;
  assign mem_addr = mem_rd ? pc + ADDR_W'(cnt) : '0;
  assign capture = (state == FETCH && cnt != 2'd0) || state == DRAIN;
  assign inst = inst_q;
  assign inst_valid = state == VALID;
  assign halted = state == IDLE;
  assign stack_err = err_q;
  avg_ret_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (AVG_RTS_W'(pc_seq)),
    .data      (rts_top),
    .full      (full),
    .empty     (empty)
  );
  // next state and PC; handshake priority is halt > ret > jmp > sequential
  always_comb begin
    state_n = state;
    pc_n = pc;
    if (state == IDLE && go) begin
      state_n = FETCH;
      pc_n = '0;
    end else if (state == FETCH) state_n = cnt == 2'd3 ? DRAIN : FETCH;
    else if (state == DRAIN) state_n = VALID;
    else if (hs) begin
      state_n = (halt || (ret && empty)) ? IDLE : FETCH;
      pc_n = halt ? pc : ret ? (empty ? pc : ADDR_W'(rts_top)) : jmp ? jump_addr[ADDR_W-1:0] : pc_seq;
    end
  end
  // state, PC, byte counter, assembly register and sticky stack fault
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
      inst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= state == FETCH ? cnt + 2'd1 : 2'd0;
      if (capture) inst_q[{byte_lane(cnt - 2'd1), 3'b000} +: 8] <= mem_data;
      err_q <= (state == IDLE && go) ? 1'b0 : err_q | (do_push & full) | (do_pop & empty);
    end
  end
endmodule
